mem_data_access_ctrl: RTL and testbench
=======================================

# mem_data_access_ctrl

Data-side bus initiator for the MEM stage. It turns the MEM stage's load/store request (read/write flags, byte select, address, store data) into an SRAM-like request/response transaction and stalls the pipeline while the access is outstanding. It captures the returned load word into a holding register and presents it on `ram_read_data_out`, which feeds the MEM/WB pipeline register's asynchronous RAM-data path. It is the requesting end of the data RAM interface whose response data MEM/WB forwards to write-back.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the bus address.
- `DATA_WIDTH`, 32, width of the read and write data.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall_other`  in  1  stall of the MEM stage from any source other than this block.
- `flush`  in  1  cancel the access belonging to the current MEM instruction.
- `mem_read_flag_in`  in  1  MEM instruction is a load.
- `mem_write_flag_in`  in  1  MEM instruction is a store.
- `mem_sel_in`  in  4  byte lane select.
- `mem_addr_in`  in  ADDR_WIDTH  effective address.
- `mem_write_data_in`  in  DATA_WIDTH  store data, already lane-aligned.
- `bus_req`  out  1  request valid.
- `bus_wr`  out  1  1 = write, 0 = read.
- `bus_size`  out  2  0 = byte, 1 = half, 2 = word.
- `bus_addr`  out  ADDR_WIDTH  request address.
- `bus_wdata`  out  DATA_WIDTH  write data.
- `bus_addr_ok`  in  1  request accepted.
- `bus_data_ok`  in  1  response valid; read data is on `bus_rdata`.
- `bus_rdata`  in  DATA_WIDTH  read data.
- `stall_request`  out  1  hold the pipeline at MEM and earlier stages.
- `ram_read_data_out`  out  DATA_WIDTH  last captured load word, to MEM/WB.

## Operation
- States: IDLE, REQ, WAIT, DONE. Reset enters IDLE.
- Reset values: `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata` are 0; `ram_read_data_out` is 0; the discard flag is 0.
- An access is present when `mem_read_flag_in | mem_write_flag_in`. Read and write both high at once is illegal; read wins.
- IDLE:
  - An access present with `flush` = 0 latches the request registers and moves to REQ.
  - `bus_wr` = write flag.
  - `bus_size`: 2 for sel 1111, 1 for 0011 or 1100, 0 for one-hot; any other sel is treated as size 2.
  - `bus_addr` = {addr[ADDR_WIDTH-1:2], offset}, where offset is the index of the lowest set bit of sel.
- REQ:
  - `bus_req` = 1 and all bus outputs stay stable until `bus_addr_ok`.
  - `bus_addr_ok` moves to WAIT. If `bus_data_ok` arrives in the same cycle, the response is handled as in WAIT.
  - `flush` with `bus_addr_ok` = 0 returns to IDLE; the request is withdrawn.
  - `flush` with `bus_addr_ok` = 1 sets the discard flag and moves to WAIT.
- WAIT:
  - `bus_req` = 0.
  - On `bus_data_ok`: for a read with discard = 0, capture `bus_rdata` into `ram_read_data_out` and go to DONE. Otherwise clear discard and go to IDLE.
  - A write goes to DONE on `bus_data_ok`.
- DONE:
  - The access is complete. A new access is not reissued while the same instruction is held.
  - `flush` = 1 or `stall_other` = 0 returns to IDLE; otherwise DONE is held.
- `flush` arriving in WAIT sets discard; the block still waits for `bus_data_ok`, because at most one request is ever outstanding.
- `ram_read_data_out` changes only on a read capture. Writes and discarded reads leave it unchanged.

## Timing
- `stall_request` = (IDLE & access present & !flush) | REQ | WAIT | (WAIT-to-IDLE discard path). It is combinational from state and inputs and is 0 in DONE.
- Minimum load occupancy is 3 cycles:
  - C0: IDLE, stall.
  - C1: REQ, `addr_ok` and `data_ok` both high, stall.
  - C2: DONE, stall low, data valid.
  - The pipeline advances at the end of C2, and MEM/WB samples `ram_read_data_out` in that cycle.
- Each extra cycle of `addr_ok` or `data_ok` latency adds one stalled cycle.
- `bus_req` is registered and never combinationally dependent on `bus_addr_ok`.
- Asserting `rst` mid-transaction forces IDLE immediately. A response from the bus after reset is ignored because the block is in IDLE.

## Test plan
- Load word at addr 0x100, sel 1111; `addr_ok` and `data_ok` both in C1 with rdata 0xDEADBEEF. Required: size 2, addr 0x100, stall high in C0–C1, DONE in C2 with `ram_read_data_out` = 0xDEADBEEF.
- Store byte at 0x203, sel 1000, data 0x5A000000. Required: `bus_wr` = 1, size 0, addr 0x203; after `data_ok`, `ram_read_data_out` keeps its previous value.
- Load with `addr_ok` delayed 3 cycles and `data_ok` 2 cycles later. Required: bus outputs stable throughout REQ, `stall_request` high for 6 cycles, data captured on `data_ok`.
- `flush` during REQ before `addr_ok`. Required: `bus_req` low next cycle, IDLE, no capture.
- `flush` in the `addr_ok` cycle, then `data_ok` with rdata 0x12345678. Required: discard, `ram_read_data_out` unchanged, stall held until `data_ok`.
- `stall_other` held 4 cycles in DONE. Required: `bus_req` stays 0 (no reissue), data held; IDLE the cycle after `stall_other` drops.

Source files
------------

// File: rtl/mem_data_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_data_access_ctrl
//
// Data-side bus initiator for the MEM stage. Converts the MEM stage's
// load/store request into a single SRAM-like request/response transaction,
// stalls the pipeline while that transaction is outstanding, and holds the
// last returned load word for the MEM/WB register.
//
// Ports:
//   clk, rst            - clock (rising edge) and asynchronous active-low reset
//   stall_other         - MEM stage held by some other source
//   flush               - cancel the access of the current MEM instruction
//   mem_read_flag_in    - MEM instruction is a load (wins over store)
//   mem_write_flag_in   - MEM instruction is a store
//   mem_sel_in          - byte lane select
//   mem_addr_in         - effective address
//   mem_write_data_in   - lane-aligned store data
//   bus_req/wr/size/addr/wdata - registered request side of the data bus
//   bus_addr_ok         - request accepted
//   bus_data_ok         - response valid, load data on bus_rdata
//   bus_rdata           - load data from the bus
//   stall_request       - hold MEM and earlier stages
//   ram_read_data_out   - last captured load word
// ---------------------------------------------------------------------------
module mem_data_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_other,
    input  logic                  flush,
    input  logic                  mem_read_flag_in,
    input  logic                  mem_write_flag_in,
    input  logic [3:0]            mem_sel_in,
    input  logic [ADDR_WIDTH-1:0] mem_addr_in,
    input  logic [DATA_WIDTH-1:0] mem_write_data_in,
    output logic                  bus_req,
    output logic                  bus_wr,
    output logic [1:0]            bus_size,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  stall_request,
    output logic [DATA_WIDTH-1:0] ram_read_data_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    busReq_q;
    logic                    busWr_q;
    logic [1:0]              busSize_q;
    logic [ADDR_WIDTH-1:0]   busAddr_q;
    logic [DATA_WIDTH-1:0]   busWdata_q;
    logic [DATA_WIDTH-1:0]   readData_q;
    logic                    discard_q;

    logic                    accessPresent;
    logic [1:0]              reqSize_d;
    logic [1:0]              reqOffset_d;
    logic [ADDR_WIDTH-1:0]   reqAddr_d;
    logic                    respDiscard;
    logic                    unusedAddrLow;

    assign accessPresent = mem_read_flag_in | mem_write_flag_in;

    // A flush arriving in the same cycle as the response still discards it.
    assign respDiscard   = discard_q | flush;

    // The low address bits are rebuilt from the byte select instead.
    assign unusedAddrLow = ^mem_addr_in[1:0];

    // Access size from the byte select; unusual patterns fall back to a word.
    always_comb begin
        reqSize_d = 2'd2;
        case (mem_sel_in)
            4'b1111:                            reqSize_d = 2'd2;
            4'b0011, 4'b1100:                   reqSize_d = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: reqSize_d = 2'd0;
            default:                            reqSize_d = 2'd2;
        endcase
    end

    // Byte offset is the position of the lowest enabled lane.
    always_comb begin
        reqOffset_d = 2'd0;
        if (mem_sel_in[0]) begin
            reqOffset_d = 2'd0;
        end else if (mem_sel_in[1]) begin
            reqOffset_d = 2'd1;
        end else if (mem_sel_in[2]) begin
            reqOffset_d = 2'd2;
        end else if (mem_sel_in[3]) begin
            reqOffset_d = 2'd3;
        end
    end

    assign reqAddr_d = {mem_addr_in[ADDR_WIDTH-1:2], reqOffset_d};

    // Transaction FSM. All bus outputs are registered so bus_req never
    // depends combinationally on bus_addr_ok; at most one request is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            busReq_q   <= 1'b0;
            busWr_q    <= 1'b0;
            busSize_q  <= 2'd0;
            busAddr_q  <= '0;
            busWdata_q <= '0;
            readData_q <= '0;
            discard_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accessPresent && !flush) begin
                        busReq_q   <= 1'b1;
                        busWr_q    <= mem_write_flag_in & ~mem_read_flag_in;
                        busSize_q  <= reqSize_d;
                        busAddr_q  <= reqAddr_d;
                        busWdata_q <= mem_write_data_in;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (bus_addr_ok) begin
                        busReq_q <= 1'b0;
                        if (bus_data_ok) begin
                            // Zero-latency response: resolve it as WAIT would.
                            if (respDiscard) begin
                                discard_q <= 1'b0;
                                state_q   <= IDLE;
                            end else begin
                                if (!busWr_q) begin
                                    readData_q <= bus_rdata;
                                end
                                state_q <= DONE;
                            end
                        end else begin
                            discard_q <= flush;
                            state_q   <= WAIT;
                        end
                    end else if (flush) begin
                        // Never accepted, so the request can simply be withdrawn.
                        busReq_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus_data_ok) begin
                        if (respDiscard) begin
                            discard_q <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            if (!busWr_q) begin
                                readData_q <= bus_rdata;
                            end
                            state_q <= DONE;
                        end
                    end else if (flush) begin
                        discard_q <= 1'b1;
                    end
                end
                DONE: begin
                    // Stay here while the same instruction is held so it is not reissued.
                    if (flush || !stall_other) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_request = ((state_q == IDLE) && accessPresent && !flush)
                         || (state_q == REQ)
                         || (state_q == WAIT);

    assign bus_req           = busReq_q;
    assign bus_wr            = busWr_q;
    assign bus_size          = busSize_q;
    assign bus_addr          = busAddr_q;
    assign bus_wdata         = busWdata_q;
    assign ram_read_data_out = readData_q;

endmodule

// File: tb/tb_mem_data_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_data_access_ctrl
//
// Directed bench for mem_data_access_ctrl. Each cycle the bench drives the
// MEM-stage request and the bus handshake, then compares outputs against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_data_access_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_other;
    logic        flush;
    logic        mem_read_flag_in;
    logic        mem_write_flag_in;
    logic [3:0]  mem_sel_in;
    logic [31:0] mem_addr_in;
    logic [31:0] mem_write_data_in;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        stall_request;
    logic [31:0] ram_read_data_out;

    int vectors;
    int miscompares;
    int stallCount;

    mem_data_access_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_other       (stall_other),
        .flush             (flush),
        .mem_read_flag_in  (mem_read_flag_in),
        .mem_write_flag_in (mem_write_flag_in),
        .mem_sel_in        (mem_sel_in),
        .mem_addr_in       (mem_addr_in),
        .mem_write_data_in (mem_write_data_in),
        .bus_req           (bus_req),
        .bus_wr            (bus_wr),
        .bus_size          (bus_size),
        .bus_addr          (bus_addr),
        .bus_wdata         (bus_wdata),
        .bus_addr_ok       (bus_addr_ok),
        .bus_data_ok       (bus_data_ok),
        .bus_rdata         (bus_rdata),
        .stall_request     (stall_request),
        .ram_read_data_out (ram_read_data_out)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one MEM-stage instruction.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] sel,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        mem_read_flag_in  = rd;
        mem_write_flag_in = wr;
        mem_sel_in        = sel;
        mem_addr_in       = addr;
        mem_write_data_in = wdata;
    endtask

    // Drives the bus response side.
    task automatic setBus(input logic addrOk, input logic dataOk, input logic [31:0] rdata);
        bus_addr_ok = addrOk;
        bus_data_ok = dataOk;
        bus_rdata   = rdata;
    endtask

    // Advances to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        stall_other = 1'b0;
        flush       = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setBus(1'b0, 1'b0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst bus_req", bus_req, 32'd0);
        checkOutput("rst bus_wr", bus_wr, 32'd0);
        checkOutput("rst bus_size", bus_size, 32'd0);
        checkOutput("rst bus_addr", bus_addr, 32'h0);
        checkOutput("rst bus_wdata", bus_wdata, 32'h0);
        checkOutput("rst ram_data", ram_read_data_out, 32'h0);
        checkOutput("rst stall", stall_request, 32'd0);
        rst = 1'b1;

        // Load word, zero-latency bus
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
        #1;
        checkOutput("t1 c0 stall", stall_request, 32'd1);
        checkOutput("t1 c0 req", bus_req, 32'd0);
        nextCycle();
        checkOutput("t1 c1 req", bus_req, 32'd1);
        checkOutput("t1 c1 wr", bus_wr, 32'd0);
        checkOutput("t1 c1 size", bus_size, 32'd2);
        checkOutput("t1 c1 addr", bus_addr, 32'h100);
        setBus(1'b1, 1'b1, 32'hDEADBEEF);
        #1;
        checkOutput("t1 c1 stall", stall_request, 32'd1);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t1 c2 stall", stall_request, 32'd0);
        checkOutput("t1 c2 data", ram_read_data_out, 32'hDEADBEEF);
        checkOutput("t1 c2 req", bus_req, 32'd0);
        nextCycle();

        // Store byte to 0x203
        applyStimulus(1'b0, 1'b1, 4'b1000, 32'h203, 32'h5A000000);
        #1;
        checkOutput("t2 c0 stall", stall_request, 32'd1);
        nextCycle();
        checkOutput("t2 c1 req", bus_req, 32'd1);
        checkOutput("t2 c1 wr", bus_wr, 32'd1);
        checkOutput("t2 c1 size", bus_size, 32'd0);
        checkOutput("t2 c1 addr", bus_addr, 32'h203);
        checkOutput("t2 c1 wdata", bus_wdata, 32'h5A000000);
        setBus(1'b1, 1'b0, 32'h0);
        nextCycle();
        setBus(1'b0, 1'b1, 32'hFFFFFFFF);
        #1;
        checkOutput("t2 c2 req", bus_req, 32'd0);
        checkOutput("t2 c2 stall", stall_request, 32'd1);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t2 c3 stall", stall_request, 32'd0);
        checkOutput("t2 c3 data", ram_read_data_out, 32'hDEADBEEF);
        nextCycle();

        // Halfword load with addr_ok in cycle 3 and data_ok in cycle 5
        applyStimulus(1'b1, 1'b0, 4'b1100, 32'h300, 32'h0);
        stallCount = 0;
        for (int c = 0; c < 7; c++) begin
            setBus(c == 3, c == 5, (c == 5) ? 32'hCAFEF00D : 32'h0);
            #1;
            if (stall_request) begin
                stallCount++;
            end
            if (c >= 1 && c <= 3) begin
                checkOutput("t3 req", bus_req, 32'd1);
                checkOutput("t3 addr", bus_addr, 32'h302);
                checkOutput("t3 size", bus_size, 32'd1);
            end
            if (c == 6) begin
                checkOutput("t3 data", ram_read_data_out, 32'hCAFEF00D);
            end
            nextCycle();
        end
        checkOutput("t3 stall cycles", stallCount, 32'd6);

        // Read and write both set, flushed in REQ before acceptance
        applyStimulus(1'b1, 1'b1, 4'b0001, 32'h404, 32'hFFFFFFFF);
        #1;
        checkOutput("t4 c0 stall", stall_request, 32'd1);
        nextCycle();
        checkOutput("t4 c1 req", bus_req, 32'd1);
        checkOutput("t4 c1 wr", bus_wr, 32'd0);
        checkOutput("t4 c1 size", bus_size, 32'd0);
        checkOutput("t4 c1 addr", bus_addr, 32'h404);
        flush = 1'b1;
        nextCycle();
        flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("t4 c2 req", bus_req, 32'd0);
        checkOutput("t4 c2 stall", stall_request, 32'd0);
        checkOutput("t4 c2 data", ram_read_data_out, 32'hCAFEF00D);
        nextCycle();

        // Flush in the addr_ok cycle; the later response is discarded
        applyStimulus(1'b1, 1'b0, 4'b0010, 32'h500, 32'h0);
        nextCycle();
        checkOutput("t5 c1 addr", bus_addr, 32'h501);
        checkOutput("t5 c1 size", bus_size, 32'd0);
        flush = 1'b1;
        setBus(1'b1, 1'b0, 32'h0);
        nextCycle();
        flush = 1'b0;
        setBus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        checkOutput("t5 c2 stall", stall_request, 32'd1);
        checkOutput("t5 c2 req", bus_req, 32'd0);
        nextCycle();
        setBus(1'b0, 1'b1, 32'h12345678);
        #1;
        checkOutput("t5 c3 stall", stall_request, 32'd1);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t5 c4 stall", stall_request, 32'd0);
        checkOutput("t5 c4 data", ram_read_data_out, 32'hCAFEF00D);
        nextCycle();

        // Load then hold DONE with stall_other for 4 cycles
        applyStimulus(1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
        nextCycle();
        setBus(1'b1, 1'b1, 32'h0BADF00D);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        stall_other = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("t6 hold req", bus_req, 32'd0);
            checkOutput("t6 hold stall", stall_request, 32'd0);
            checkOutput("t6 hold data", ram_read_data_out, 32'h0BADF00D);
            nextCycle();
        end
        stall_other = 1'b0;
        #1;
        checkOutput("t6 release stall", stall_request, 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 4'b0110, 32'h700, 32'h0);
        #1;
        checkOutput("t6 idle stall", stall_request, 32'd1);
        checkOutput("t6 idle req", bus_req, 32'd0);
        nextCycle();
        checkOutput("t6 odd sel req", bus_req, 32'd1);
        checkOutput("t6 odd sel size", bus_size, 32'd2);
        checkOutput("t6 odd sel addr", bus_addr, 32'h701);

        // Reset in the middle of a request, then a stray response
        rst = 1'b0;
        #1;
        checkOutput("t7 rst req", bus_req, 32'd0);
        checkOutput("t7 rst addr", bus_addr, 32'h0);
        checkOutput("t7 rst data", ram_read_data_out, 32'h0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setBus(1'b0, 1'b1, 32'h77777777);
        nextCycle();
        setBus(1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t7 stray data", ram_read_data_out, 32'h0);
        checkOutput("t7 stray stall", stall_request, 32'd0);
        checkOutput("t7 stray req", bus_req, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
